// File: rtl/video_timing_ctrl_if.sv
// Configuration and line-fetch bus of the video timing controller.
// The slave modport is the timing controller; the master modport is the
// host / framebuffer side that writes timing shadows and answers fetches.
interface video_timing_ctrl_if;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [10:0] cfg_data;
    logic        fetch_ack;
    logic        fetch_req;
    logic [10:0] fetch_line;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        output fetch_ack,
        input  fetch_req,
        input  fetch_line
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        input  fetch_ack,
        output fetch_req,
        output fetch_line
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// Video timing generator: double-buffered timing registers (shadow copies
// committed at frame end or while disabled), X/Y raster counters, registered
// sync / data-enable / frame-start outputs and a one-line-ahead fetch FSM
// with a sticky underflow flag.
module video_timing_ctrl (
    input  logic                 pixclk,
    input  logic                 rst,
    input  logic                 en,
    video_timing_ctrl_if.slave   bus,
    output logic [10:0]          counter_x,
    output logic [10:0]          counter_y,
    output logic                 hSync,
    output logic                 vSync,
    output logic                 DrawArea,
    output logic                 frame_start,
    output logic                 underflow
);

    localparam logic [2:0] H_ACTIVE     = 3'd0;
    localparam logic [2:0] H_SYNC_START = 3'd1;
    localparam logic [2:0] H_SYNC_END   = 3'd2;
    localparam logic [2:0] H_LAST       = 3'd3;
    localparam logic [2:0] V_ACTIVE     = 3'd4;
    localparam logic [2:0] V_SYNC_START = 3'd5;
    localparam logic [2:0] V_SYNC_END   = 3'd6;
    localparam logic [2:0] V_LAST       = 3'd7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_LINE = 2'd2
    } fetch_state_t;

    // Power-on timing: 800x600 at 60 Hz, 40 MHz pixel clock.
    function automatic logic [10:0] reg_default(input logic [2:0] idx);
        logic [10:0] val;
        case (idx)
            H_ACTIVE:     val = 11'd800;
            H_SYNC_START: val = 11'd840;
            H_SYNC_END:   val = 11'd968;
            H_LAST:       val = 11'd1055;
            V_ACTIVE:     val = 11'd600;
            V_SYNC_START: val = 11'd601;
            V_SYNC_END:   val = 11'd605;
            V_LAST:       val = 11'd627;
            default:      val = 11'd0;
        endcase
        return val;
    endfunction

    logic [10:0]  shadow_r [8];
    logic [10:0]  active_r [8];
    logic [10:0]  shadow_next_s [8];
    logic [10:0]  x_r;
    logic [10:0]  y_r;
    logic         hsync_r;
    logic         vsync_r;
    logic         draw_r;
    logic         frame_start_r;
    logic         fetch_req_r;
    logic [10:0]  fetch_line_r;
    logic         underflow_r;
    fetch_state_t state_r;
    logic         line_end_s;
    logic         frame_end_s;
    logic         commit_s;
    logic         fetch_start_s;

    // Shadow values after this cycle's write, line/frame end and commit strobes.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            if (bus.cfg_we && (bus.cfg_addr == 3'(i))) begin
                shadow_next_s[i] = bus.cfg_data;
            end else begin
                shadow_next_s[i] = shadow_r[i];
            end
        end
        line_end_s    = (x_r == active_r[H_LAST]);
        frame_end_s   = line_end_s && (y_r == active_r[V_LAST]);
        commit_s      = (en && frame_end_s) || !en;
        // Prefetch the next line (or line 0 from the last line); the last
        // visible line has no successor inside the active area.
        fetch_start_s = (x_r == active_r[H_ACTIVE]) &&
                        ((y_r < (active_r[V_ACTIVE] - 11'd1)) || (y_r == active_r[V_LAST]));
    end

    // Shadow writes and shadow-to-active commit; a write on the commit cycle is included.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= reg_default(3'(i));
                active_r[i] <= reg_default(3'(i));
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                shadow_r[i] <= shadow_next_s[i];
                if (commit_s) begin
                    active_r[i] <= shadow_next_s[i];
                end else begin
                    active_r[i] <= active_r[i];
                end
            end
        end
    end

    // Raster counters, registered timing outputs and the line-fetch FSM.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            x_r           <= 11'd0;
            y_r           <= 11'd0;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            draw_r        <= 1'b0;
            frame_start_r <= 1'b0;
            fetch_req_r   <= 1'b0;
            fetch_line_r  <= 11'd0;
            underflow_r   <= 1'b0;
            state_r       <= IDLE;
        end else if (!en) begin
            x_r           <= 11'd0;
            y_r           <= 11'd0;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            draw_r        <= 1'b0;
            frame_start_r <= 1'b0;
            fetch_req_r   <= 1'b0;
            state_r       <= IDLE;
        end else begin
            if (line_end_s) begin
                x_r <= 11'd0;
                y_r <= (y_r == active_r[V_LAST]) ? 11'd0 : (y_r + 11'd1);
            end else begin
                x_r <= x_r + 11'd1;
            end
            hsync_r       <= (x_r >= active_r[H_SYNC_START]) && (x_r < active_r[H_SYNC_END]);
            vsync_r       <= (y_r >= active_r[V_SYNC_START]) && (y_r < active_r[V_SYNC_END]);
            draw_r        <= (x_r < active_r[H_ACTIVE]) && (y_r < active_r[V_ACTIVE]);
            frame_start_r <= (x_r == 11'd0) && (y_r == 11'd0);

            case (state_r)
                IDLE: begin
                    if (fetch_start_s) begin
                        state_r      <= REQ;
                        fetch_req_r  <= 1'b1;
                        fetch_line_r <= (y_r == active_r[V_LAST]) ? 11'd0 : (y_r + 11'd1);
                    end else begin
                        fetch_req_r  <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.fetch_ack) begin
                        // An ack on the wrap cycle completes the fetch and frees
                        // the FSM for the line that is just starting.
                        state_r     <= line_end_s ? IDLE : WAIT_LINE;
                        fetch_req_r <= 1'b0;
                    end else if (line_end_s) begin
                        state_r     <= IDLE;
                        fetch_req_r <= 1'b0;
                        underflow_r <= 1'b1;
                    end else begin
                        fetch_req_r <= 1'b1;
                    end
                end
                WAIT_LINE: begin
                    fetch_req_r <= 1'b0;
                    if (line_end_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_LINE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    fetch_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign counter_x      = x_r;
    assign counter_y      = y_r;
    assign hSync          = hsync_r;
    assign vSync          = vsync_r;
    assign DrawArea       = draw_r;
    assign frame_start    = frame_start_r;
    assign underflow      = underflow_r;
    assign bus.fetch_req  = fetch_req_r;
    assign bus.fetch_line = fetch_line_r;

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 SHALL have port pixclk, input, 1, pixel clock; the sole clock, and all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port en, input, 1, timing enable; low freezes the generator at its idle point.
REQ-004 SHALL have port cfg_we, input, 1, shadow-register write strobe.
REQ-005 SHALL have port cfg_addr, input, 3, shadow-register select.
REQ-006 SHALL have port cfg_data, input, 11, shadow-register write value.
REQ-007 SHALL have port fetch_ack, input, 1, line-fetch acknowledge from the framebuffer.
REQ-008 SHALL have port counter_x, output, 11, current horizontal position.
REQ-009 SHALL have port counter_y, output, 11, current vertical position.
REQ-010 SHALL have port hSync, output, 1, horizontal sync, registered, active-high.
REQ-011 SHALL have port vSync, output, 1, vertical sync, registered, active-high.
REQ-012 SHALL have port DrawArea, output, 1, video data enable for the TMDS encoders, registered.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse at X=0,Y=0.
REQ-014 SHALL have port fetch_req, output, 1, line-fetch request.
REQ-015 SHALL have port fetch_line, output, 11, line number being requested.
REQ-016 SHALL have port underflow, output, 1, sticky missed-fetch flag.

Function
REQ-017 SHALL hold 8 shadow and 8 active 11-bit timing registers, addressed by cfg_addr as follows (reset value in brackets): 0 h_active [800], 1 h_sync_start [840], 2 h_sync_end [968], 3 h_last [1055], 4 v_active [600], 5 v_sync_start [601], 6 v_sync_end [605], 7 v_last [627].
REQ-018 SHALL write cfg_data into shadow[cfg_addr] on any cycle with cfg_we=1; shadow writes never affect timing directly.
REQ-019 SHALL copy all shadow registers to the active registers on the cycle counter_x==h_last and counter_y==v_last (frame end), and also whenever en=0.
REQ-020 SHALL, on a cfg_we coinciding with the frame-end commit, commit the newly written value in that same cycle.
REQ-021 SHALL advance counter_x by 1 each cycle while en=1, wrapping from h_last to 0.
REQ-022 SHALL advance counter_y by 1 when counter_x wraps, wrapping from v_last to 0.
REQ-023 SHALL use all counter arithmetic modulo 2^11 and SHALL NOT range-check configuration values; inconsistent values give undefined timing but never lock up the logic.
REQ-024 SHALL register hSync <= (X>=h_sync_start && X<h_sync_end), so it lags the counters by one cycle.
REQ-025 SHALL register vSync <= (Y>=v_sync_start && Y<v_sync_end), so it lags the counters by one cycle.
REQ-026 SHALL register DrawArea <= (X<h_active && Y<v_active), so it lags the counters by one cycle.
REQ-027 SHALL register frame_start high for exactly one cycle after the cycle with X=0,Y=0 while en=1.
REQ-028 SHALL, while en=0, hold the counters at 0, force hSync, vSync, DrawArea, frame_start and fetch_req to 0, and leave underflow unchanged.
REQ-029 SHALL implement a fetch FSM with states IDLE, REQ and WAIT_LINE.
REQ-030 SHALL go IDLE->REQ at X==h_active when (Y<v_active-1) or (Y==v_last), setting fetch_line to Y+1, or to 0 when Y==v_last.
REQ-031 SHALL assert fetch_req=1 and hold fetch_line stable in REQ.
REQ-032 SHALL go REQ->WAIT_LINE when fetch_ack=1; fetch_req drops the next cycle.
REQ-033 SHALL go WAIT_LINE->IDLE at the next X wrap to 0.
REQ-034 SHALL, if still in REQ when X wraps to 0 with fetch_ack=0, set underflow=1 and go to IDLE.
REQ-035 SHALL treat fetch_ack=1 on the wrap cycle as success with no underflow.
REQ-036 SHALL ignore fetch_ack outside REQ.
REQ-037 SHALL keep underflow set until rst.
REQ-038 SHALL, when en falls, return the FSM to IDLE immediately, with no underflow.

Reset
REQ-039 SHALL, on rst=1 at a pixclk edge, load shadow and active registers with their REQ-017 reset values.
REQ-040 SHALL, on rst=1 at a pixclk edge, set counters to 0, outputs to 0, FSM to IDLE and underflow to 0.
REQ-041 SHALL let rst override en, cfg_we and fetch_ack.
REQ-042 SHALL abandon any fetch in progress when rst is asserted mid-frame, with no underflow.

Verification
REQ-043 Defaults with en=1, fetch_ack tied 1 -> hSync high 128 cycles per 1056-cycle line; vSync high 4 lines per 628-line frame; DrawArea high 800x600; underflow stays 0.
REQ-044 Write h_active=640 mid-frame -> DrawArea width stays 800 until frame_start, then becomes 640.
REQ-045 fetch_ack held 0 -> fetch_req rises at X=800,Y=0 with fetch_line=1; at wrap, underflow=1 and fetch_req=0.
REQ-046 fetch_ack pulsed 5 cycles after req -> fetch_req falls one cycle later; no underflow. Ack on the wrap cycle -> no underflow.
REQ-047 Y=627, X=800 -> fetch_line=0. Y=599 -> no request.
REQ-048 rst asserted mid-REQ and mid-frame -> next cycle counters=0, fetch_req=0, underflow=0, registers at defaults. en low for 10 cycles -> outputs 0 and counters 0; restart from X=0,Y=0 gives frame_start.
